mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
// Upstream sequencer for the 1024x12 scratch memory. Accepts whole-word read/write requests over a
// valid/ready handshake and drives the memory's narrow command bus, which carries 10-bit values.
// Splits each 12-bit write into an address cycle plus one or two 6-bit half-commit cycles.
// Also sequences memory dump requests and returns read data and completion pulses to the requester.
// PARAMETERS
// ADDR_W  10  memory address width; also the width of the command bus.
// DATA_W  12  memory word width; must be even. HALF = DATA_W/2. Requires HALF+1 <= ADDR_W.
// PORTS
// clk           in   1       clock; every register updates on the rising edge.
// rst           in   1       reset: asynchronous, active-high.
// req_valid     in   1       request present.
// req_ready     out  1       request accepted when req_valid && req_ready.
// req_write     in   1       1 = write request, 0 = read request.
// req_addr      in   ADDR_W  word address.
// req_wdata     in   DATA_W  write data.
// req_wmask     in   2       write mask: bit0 = low half [HALF-1:0], bit1 = high half [DATA_W-1:HALF].
// dump_req      in   1       one-cycle pulse requesting a memory dump.
// resp_valid    out  1       one-cycle pulse: request complete.
// resp_write    out  1       type of the completed request; valid with resp_valid.
// resp_rdata    out  DATA_W  read data; valid with resp_valid when resp_write = 0.
// dump_done     out  1       one-cycle pulse: dump issued.
// busy          out  1       FSM not in IDLE, or a dump is pending.
// mem_read_write   out  1       memory bus: 1 = read (no write side effect).
// mem_write_commit out  1       memory bus: 1 = commit half-word.
// mem_dump         out  1       memory bus: dump strobe.
// mem_addr_data    out  ADDR_W  memory bus: address or {select, half data}.
// mem_result       in   DATA_W  memory read data; combinational in the same cycle.
// BEHAVIOUR
// - All outputs are registered. Exception: req_ready and busy are decoded from registered state.
// - Reset values: mem_read_write=1, mem_write_commit=0, mem_dump=0, mem_addr_data=0.
//   Also: resp_valid=0, resp_write=0, resp_rdata=0, dump_done=0, dump_pend=0, state=IDLE.
// - Idle bus value: read_write=1, commit=0, addr_data=0. This never modifies memory or its address latch.
// - req_ready = (state==IDLE) && !dump_pend && !dump_req. Request fields are captured at acceptance.
// - States and bus values (shown on bus while in state): IDLE, WR_ADDR, WR_LO, WR_HI, RD, DUMP.
// - Write accepted in cycle N, both mask bits set:
//   - N+1 WR_ADDR: rw=0, commit=0, addr_data=addr.
//   - N+2 WR_LO: rw=0, commit=1, addr_data = zero-extended {1'b0, wdata[HALF-1:0]}.
//   - N+3 WR_HI: rw=0, commit=1, addr_data = zero-extended {1'b1, wdata[DATA_W-1:HALF]}.
//   - N+4 IDLE: resp_valid=1, resp_write=1.
// - Write with a single mask bit: the unselected half state is skipped; resp_valid comes one cycle earlier.
// - Write with wmask=00: no bus activity at all; resp_valid at N+1.
// - Read accepted at N:
//   - N+1 RD: rw=1, commit=0, addr_data=addr. mem_result is registered into resp_rdata at the end of N+1.
//   - N+2: resp_valid=1, resp_write=0.
// - Back-to-back: IDLE may accept a new request in the same cycle resp_valid is asserted.
// - dump_req sets the sticky dump_pend whenever it is seen, including while busy.
// - In IDLE, a pending dump takes priority over req_valid. One DUMP cycle follows (rw=1, commit=0, mem_dump=1).
//   The next cycle dump_done=1 and dump_pend clears.
//   A dump_req arriving during the DUMP cycle re-sets dump_pend.
// - There is no resp backpressure: the requester must sink resp_valid.
// - rst asserted mid-operation: immediate return to reset values.
//   No half-commit is completed or replayed, and the pending dump is dropped.
// TESTING
// - Reset, then idle 5 cycles -> bus holds rw=1, commit=0, addr=0; req_ready=1; no resp/dump pulses.
// - Write addr=0x2A5, wdata=0xABC, mask=11:
//   - -> bus values over 3 cycles: 0x2A5(commit=0), 0x03C(commit=1), 0x06A(commit=1).
//   - -> resp_valid at N+4; a later read of 0x2A5 returns 0xABC.
// - Write addr=0x001, wdata=0xFFF, mask=01 over a word holding 0x000 -> one commit of 0x03F; readback 0x03F.
//   Then mask=00 -> resp at N+1, no commit.
// - Read addr=0x3FF with memory model holding 0x5A5 -> RD drives addr 0x3FF, rw=1; resp_rdata=0x5A5 at N+2.
// - dump_req during WR_LO of a write -> write completes unaltered, then DUMP cycle (mem_dump=1), then dump_done.
//   A req_valid held throughout is accepted only after the dump.
// - rst pulse during WR_HI -> all outputs at reset values the same cycle; high half not written.
//   A new request is accepted normally after release.

Source files
------------

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: request/response handshake, dump control and scratch-memory
// command bus of the mem_bus_ctrl sequencer, bundled as one interface.
//   req_*      : whole-word read/write request (valid/ready handshake)
//   resp_*     : one-cycle completion pulse with type and read data
//   dump_req   : one-cycle dump request pulse; dump_done acknowledges it
//   busy       : sequencer active or dump pending
//   mem_*      : narrow command bus to the 1024x12 scratch memory; mem_result
//                is the memory's combinational read data
// modport slave  : the sequencer itself
// modport master : its environment (requester plus the memory's read data)
interface mem_bus_ctrl_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_wmask;
    logic              dump_req;
    logic              resp_valid;
    logic              resp_write;
    logic [DATA_W-1:0] resp_rdata;
    logic              dump_done;
    logic              busy;
    logic              mem_read_write;
    logic              mem_write_commit;
    logic              mem_dump;
    logic [ADDR_W-1:0] mem_addr_data;
    logic [DATA_W-1:0] mem_result;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask, dump_req, mem_result,
        output req_ready, resp_valid, resp_write, resp_rdata, dump_done, busy,
               mem_read_write, mem_write_commit, mem_dump, mem_addr_data
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask, dump_req, mem_result,
        input  req_ready, resp_valid, resp_write, resp_rdata, dump_done, busy,
               mem_read_write, mem_write_commit, mem_dump, mem_addr_data
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: upstream sequencer for the 1024x12 scratch memory.
// Accepts whole-word read/write requests and drives the memory's narrow
// command bus: a write becomes an address cycle followed by one 6-bit
// half-commit cycle per selected mask bit; a read is a single address cycle
// whose combinational result is captured into resp_rdata. Dump requests are
// made sticky and serviced from IDLE ahead of any new request.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : mem_bus_ctrl_if.slave (request, response, dump, memory bus)
module mem_bus_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 12
) (
    input  logic           clk,
    input  logic           rst,
    mem_bus_ctrl_if.slave  bus
);
    localparam int unsigned HALF = DATA_W / 2;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_LO,
        WR_HI,
        RD,
        DUMP
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        wmask_q;
    logic              dump_pend, dump_pend_n;

    // Registered outputs and their next values.
    logic              rw_q, rw_n;
    logic              commit_q, commit_n;
    logic              mdump_q, mdump_n;
    logic [ADDR_W-1:0] ad_q, ad_n;
    logic              resp_valid_q, resp_valid_n;
    logic              resp_write_q, resp_write_n;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_n;
    logic              dump_done_q, dump_done_n;

    logic              req_ready;
    logic              accept;
    logic [ADDR_W-1:0] lo_word, hi_word;

    assign req_ready = (state == IDLE) && !dump_pend && !bus.dump_req;
    assign accept    = bus.req_valid && req_ready;

    // Half-commit words: {select, half data}, zero-extended to the bus width.
    always_comb begin
        lo_word         = '0;
        hi_word         = '0;
        lo_word[HALF:0] = {1'b0, wdata_q[HALF-1:0]};
        hi_word[HALF:0] = {1'b1, wdata_q[DATA_W-1:HALF]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            dump_pend    <= 1'b0;
            rw_q         <= 1'b1;
            commit_q     <= 1'b0;
            mdump_q      <= 1'b0;
            ad_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_rdata_q <= '0;
            dump_done_q  <= 1'b0;
        end else begin
            state        <= state_n;
            dump_pend    <= dump_pend_n;
            rw_q         <= rw_n;
            commit_q     <= commit_n;
            mdump_q      <= mdump_n;
            ad_q         <= ad_n;
            resp_valid_q <= resp_valid_n;
            resp_write_q <= resp_write_n;
            resp_rdata_q <= resp_rdata_n;
            dump_done_q  <= dump_done_n;
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                wmask_q <= bus.req_wmask;
            end
        end
    end

    // Next-state logic computes the bus value shown during the *next* state,
    // so the registered bus lines up with the state it belongs to.
    always_comb begin
        state_n      = state;
        rw_n         = 1'b1;
        commit_n     = 1'b0;
        mdump_n      = 1'b0;
        ad_n         = '0;
        resp_valid_n = 1'b0;
        resp_write_n = resp_write_q;
        resp_rdata_n = resp_rdata_q;
        dump_done_n  = 1'b0;

        // A dump_req seen during the DUMP cycle itself re-arms the pending flag.
        if (bus.dump_req)
            dump_pend_n = 1'b1;
        else if (state == DUMP)
            dump_pend_n = 1'b0;
        else
            dump_pend_n = dump_pend;

        case (state)
            IDLE: begin
                if (dump_pend) begin
                    state_n = DUMP;
                    mdump_n = 1'b1;
                end else if (accept) begin
                    if (bus.req_write) begin
                        if (bus.req_wmask == 2'b00) begin
                            resp_valid_n = 1'b1;
                            resp_write_n = 1'b1;
                        end else begin
                            state_n = WR_ADDR;
                            rw_n    = 1'b0;
                            ad_n    = bus.req_addr;
                        end
                    end else begin
                        state_n = RD;
                        ad_n    = bus.req_addr;
                    end
                end
            end
            WR_ADDR: begin
                rw_n     = 1'b0;
                commit_n = 1'b1;
                if (wmask_q[0]) begin
                    state_n = WR_LO;
                    ad_n    = lo_word;
                end else begin
                    state_n = WR_HI;
                    ad_n    = hi_word;
                end
            end
            WR_LO: begin
                if (wmask_q[1]) begin
                    state_n  = WR_HI;
                    rw_n     = 1'b0;
                    commit_n = 1'b1;
                    ad_n     = hi_word;
                end else begin
                    state_n      = IDLE;
                    resp_valid_n = 1'b1;
                    resp_write_n = 1'b1;
                end
            end
            WR_HI: begin
                state_n      = IDLE;
                resp_valid_n = 1'b1;
                resp_write_n = 1'b1;
            end
            RD: begin
                state_n      = IDLE;
                resp_valid_n = 1'b1;
                resp_write_n = 1'b0;
                resp_rdata_n = bus.mem_result;
            end
            DUMP: begin
                state_n     = IDLE;
                dump_done_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.req_ready        = req_ready;
    assign bus.busy             = (state != IDLE) || dump_pend;
    assign bus.mem_read_write   = rw_q;
    assign bus.mem_write_commit = commit_q;
    assign bus.mem_dump         = mdump_q;
    assign bus.mem_addr_data    = ad_q;
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_write       = resp_write_q;
    assign bus.resp_rdata       = resp_rdata_q;
    assign bus.dump_done        = dump_done_q;

    // Unused in this configuration when the parameters are consistent; kept for clarity.
    logic unused_addr;
    assign unused_addr = ^addr_q;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: self-checking bench for mem_bus_ctrl. A bus-functional
// scratch memory reacts to the command bus; a transaction-level reference
// memory predicts read data, bus sequences and completion latency.
module tb_mem_bus_ctrl;
    localparam int unsigned AW   = 10;
    localparam int unsigned DW   = 12;
    localparam int unsigned HALF = DW / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clear = 1'b1;
    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Bus-functional memory: address cycle latches, commit writes a half.
    logic [DW-1:0] bmem [1024];
    logic [AW-1:0] mlatch;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) bmem[i] <= '0;
            mlatch <= '0;
        end else if (!rst && !bus.mem_read_write) begin
            if (!bus.mem_write_commit)
                mlatch <= bus.mem_addr_data;
            else if (bus.mem_addr_data[HALF])
                bmem[mlatch][DW-1:HALF] <= bus.mem_addr_data[HALF-1:0];
            else
                bmem[mlatch][HALF-1:0] <= bus.mem_addr_data[HALF-1:0];
        end
    end
    always_comb bus.mem_result = bmem[bus.mem_addr_data];

    // Reference model state and observations.
    logic [DW-1:0] ref_mem [1024];
    logic [12:0]   exp_q[$];
    logic [12:0]   trace[$];
    logic [DW-1:0] exp_rdata;
    int            errors = 0;
    int            checks = 0;
    int            obs_wait, obs_lat;
    logic          obs_rw;
    logic [DW-1:0] obs_rdata;

    function automatic logic [12:0] bus_now();
        return {bus.mem_read_write, bus.mem_write_commit, bus.mem_dump, bus.mem_addr_data};
    endfunction

    // Expected bus sequence of a request and its effect on the reference memory.
    task automatic model_req(input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [1:0] m);
        logic [AW-1:0] lo_v, hi_v;
        lo_v = {{(AW-HALF-1){1'b0}}, 1'b0, d[HALF-1:0]};
        hi_v = {{(AW-HALF-1){1'b0}}, 1'b1, d[DW-1:HALF]};
        exp_q.delete();
        exp_rdata = ref_mem[a];
        if (w) begin
            if (m != 2'b00) exp_q.push_back({3'b000, a});
            if (m[0]) begin exp_q.push_back({3'b010, lo_v}); ref_mem[a][HALF-1:0] = d[HALF-1:0]; end
            if (m[1]) begin exp_q.push_back({3'b010, hi_v}); ref_mem[a][DW-1:HALF] = d[DW-1:HALF]; end
        end else begin
            exp_q.push_back({3'b100, a});
        end
    endtask

    // Drives one request starting at a falling edge; returns at the falling edge
    // on which resp_valid is seen (or when the cycle budget runs out).
    task automatic do_req(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [1:0] m);
        trace.delete();
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a;
        bus.req_wdata = d;    bus.req_wmask = m;
        obs_wait = 0;
        while (!bus.req_ready && obs_wait < 20) begin @(negedge clk); obs_wait++; end
        @(negedge clk);
        bus.req_valid = 1'b0;
        obs_lat = 1;
        while (!bus.resp_valid && obs_lat < 20) begin
            trace.push_back(bus_now());
            @(negedge clk);
            obs_lat++;
        end
        obs_rw    = bus.resp_write;
        obs_rdata = bus.resp_rdata;
    endtask

    task automatic test_reset();
        logic [16:0] v;
        rst = 1'b1; mem_clear = 1'b1;
        repeat (2) @(negedge clk);
        mem_clear = 1'b0; rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            v = {bus.mem_read_write, bus.mem_write_commit, bus.mem_dump, bus.mem_addr_data,
                 bus.req_ready, bus.resp_valid, bus.dump_done, bus.busy};
            checks++;
            if (v !== {3'b100, 10'h000, 4'b1000}) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %h expected %h", i, v, {3'b100, 10'h000, 4'b1000});
            end
        end
        checks++;
        if (bus.resp_rdata !== '0 || bus.resp_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: rdata=%h write=%b expected 000/0", bus.resp_rdata, bus.resp_write);
        end
    endtask

    task automatic test_write_full();
        model_req(1'b1, 10'h2A5, 12'hABC, 2'b11);
        do_req(1'b1, 10'h2A5, 12'hABC, 2'b11);
        checks++;
        if (obs_lat !== 4 || obs_rw !== 1'b1) begin
            errors++; $display("FAIL wr_full_resp: lat=%0d write=%b expected 4/1", obs_lat, obs_rw);
        end
        checks++;
        if (trace.size() != 3 || trace[0] !== 13'h02A5 || trace[1] !== {3'b010, 10'h03C} || trace[2] !== {3'b010, 10'h06A}) begin
            errors++; $display("FAIL wr_full_bus: got %p expected 2a5/c0,03c/c1,06a/c1", trace);
        end
        model_req(1'b0, 10'h2A5, '0, 2'b00);
        do_req(1'b0, 10'h2A5, '0, 2'b00);
        checks++;
        if (obs_lat !== 2 || obs_rw !== 1'b0 || obs_rdata !== 12'hABC) begin
            errors++; $display("FAIL wr_full_readback: lat=%0d rdata=%h expected 2/abc", obs_lat, obs_rdata);
        end
    endtask

    task automatic test_write_partial();
        model_req(1'b1, 10'h001, 12'hFFF, 2'b01);
        do_req(1'b1, 10'h001, 12'hFFF, 2'b01);
        checks++;
        if (obs_lat !== 3 || trace.size() != 2 || trace[1] !== {3'b010, 10'h03F}) begin
            errors++; $display("FAIL wr_lo_only: lat=%0d bus=%p expected 3, commit 03f", obs_lat, trace);
        end
        do_req(1'b0, 10'h001, '0, 2'b00);
        checks++;
        if (obs_rdata !== 12'h03F) begin
            errors++; $display("FAIL wr_lo_readback: got %h expected 03f", obs_rdata);
        end
        model_req(1'b1, 10'h001, 12'h555, 2'b00);
        do_req(1'b1, 10'h001, 12'h555, 2'b00);
        checks++;
        if (obs_lat !== 1 || obs_rw !== 1'b1 || trace.size() != 0) begin
            errors++; $display("FAIL wr_mask00: lat=%0d bus_cycles=%0d expected 1/0", obs_lat, trace.size());
        end
        do_req(1'b0, 10'h001, '0, 2'b00);
        checks++;
        if (obs_rdata !== 12'h03F) begin
            errors++; $display("FAIL wr_mask00_readback: got %h expected 03f", obs_rdata);
        end
    endtask

    task automatic test_read();
        model_req(1'b1, 10'h3FF, 12'h5A5, 2'b11);
        do_req(1'b1, 10'h3FF, 12'h5A5, 2'b11);
        do_req(1'b0, 10'h3FF, '0, 2'b00);
        checks++;
        if (obs_lat !== 2 || trace.size() != 1 || trace[0] !== {3'b100, 10'h3FF} || obs_rdata !== 12'h5A5) begin
            errors++; $display("FAIL read_3ff: lat=%0d bus=%p rdata=%h expected 2/13'h13ff/5a5", obs_lat, trace, obs_rdata);
        end
    endtask

    task automatic test_dump();
        int n;
        model_req(1'b1, 10'h100, 12'h9C3, 2'b11);
        fork
            do_req(1'b1, 10'h100, 12'h9C3, 2'b11);
            begin
                n = 0;
                @(negedge clk);
                while (!(bus.mem_write_commit && !bus.mem_addr_data[HALF]) && n < 10) begin
                    @(negedge clk); n++;
                end
                bus.dump_req = 1'b1;
                @(negedge clk);
                bus.dump_req = 1'b0;
            end
        join
        checks++;
        if (obs_lat !== 4 || trace != exp_q) begin
            errors++; $display("FAIL dump_write: lat=%0d bus=%p expected 4 %p", obs_lat, trace, exp_q);
        end
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 10'h100;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL dump_pending: ready=%b busy=%b expected 0/1", bus.req_ready, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus_now() !== {3'b101, 10'h000} || bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL dump_cycle: bus=%h ready=%b expected 1400/0", bus_now(), bus.req_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.dump_done !== 1'b1 || bus.mem_dump !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL dump_done: done=%b dump=%b ready=%b busy=%b expected 1/0/1/0",
                               bus.dump_done, bus.mem_dump, bus.req_ready, bus.busy);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus_now() !== {3'b100, 10'h100} || bus.dump_done !== 1'b0) begin
            errors++; $display("FAIL dump_then_read: bus=%h done=%b expected 1100/0", bus_now(), bus.dump_done);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_write !== 1'b0 || bus.resp_rdata !== 12'h9C3) begin
            errors++; $display("FAIL dump_read_resp: valid=%b rdata=%h expected 1/9c3", bus.resp_valid, bus.resp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [16:0] v;
        model_req(1'b1, 10'h055, 12'h123, 2'b11);
        do_req(1'b1, 10'h055, 12'h123, 2'b11);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 10'h055;
        bus.req_wdata = 12'hFED; bus.req_wmask = 2'b11;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!(bus.mem_write_commit && bus.mem_addr_data[HALF]) && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (n >= 10) begin errors++; $display("FAIL rst_mid_reach_hi: got timeout expected WR_HI"); end
        rst = 1'b1;
        #1;
        v = {bus.mem_read_write, bus.mem_write_commit, bus.mem_dump, bus.mem_addr_data,
             bus.req_ready, bus.resp_valid, bus.dump_done, bus.busy};
        checks++;
        if (v !== {3'b100, 10'h000, 4'b1000}) begin
            errors++; $display("FAIL rst_mid_outputs: got %h expected %h", v, {3'b100, 10'h000, 4'b1000});
        end
        @(negedge clk);
        rst = 1'b0;
        ref_mem[10'h055][HALF-1:0] = 6'h2D;  // low half committed before reset, high half never
        model_req(1'b0, 10'h055, '0, 2'b00);
        do_req(1'b0, 10'h055, '0, 2'b00);
        checks++;
        if (obs_wait !== 0 || obs_lat !== 2 || obs_rdata !== 12'h12D || exp_rdata !== 12'h12D) begin
            errors++; $display("FAIL rst_mid_readback: wait=%0d lat=%0d rdata=%h expected 0/2/12d", obs_wait, obs_lat, obs_rdata);
        end
    endtask

    // Random requests issued back to back: each is offered in the resp_valid
    // cycle of the previous one and must be accepted immediately.
    task automatic test_back_to_back();
        logic w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0] m;
        for (int t = 0; t < 40; t++) begin
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = AW'($urandom);
            d = DW'($urandom);
            m = 2'($urandom_range(0, 3));
            model_req(w, a, d, m);
            do_req(w, a, d, m);
            checks++;
            if (obs_wait !== 0 || obs_lat !== exp_q.size() + 1 || obs_rw !== w) begin
                errors++; $display("FAIL b2b_%0d_timing: wait=%0d lat=%0d write=%b expected 0/%0d/%b",
                                   t, obs_wait, obs_lat, obs_rw, exp_q.size() + 1, w);
            end
            checks++;
            if (trace != exp_q) begin
                errors++; $display("FAIL b2b_%0d_bus: got %p expected %p", t, trace, exp_q);
            end
            if (!w) begin
                checks++;
                if (obs_rdata !== exp_rdata) begin
                    errors++; $display("FAIL b2b_%0d_rdata: addr=%h got %h expected %h", t, a, obs_rdata, exp_rdata);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_wmask = '0;   bus.dump_req = 1'b0;
        test_reset();
        test_write_full();
        test_write_partial();
        test_read();
        test_dump();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
